// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU control unit: controller state encoding,
// default array/address/latency constants and derived counter widths.
package tpu_ctrl_pkg;

    localparam int unsigned W_DEF             = 16;   // systolic array dimension
    localparam int unsigned ADDR_W_DEF        = 10;   // buffer address width
    localparam int unsigned BIAS_LAT_DEF      = 40;   // A-read to C-read issue distance
    localparam int unsigned DRAIN_TIMEOUT_DEF = 1024; // DRAIN cycles before abort

    localparam int unsigned K_W   = $clog2(W_DEF) + 1; // width of K/N configuration
    localparam int unsigned IDX_W = $clog2(W_DEF);     // width of weight row index

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Width of a counter that must reach the value 'limit'.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register carrying {en, addr} from each A-row read issue to
// the matching C-row read issue.
// Ports: clk, rst (sync, active-high), clr_i (sync flush of all stages),
//        en_i/addr_i (payload in), en_o/addr_o (payload DEPTH cycles later),
//        pending_o (some stage still holds an enabled entry).
module ctrl_delay_line #(
    parameter int unsigned DEPTH = 40,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    output logic          en_o,
    output logic [AW-1:0] addr_o,
    output logic          pending_o
);

    logic [AW:0]      pipe_q [DEPTH];
    logic [DEPTH-1:0] en_vec_c;

    // Shift stage by stage; a clear empties the whole line.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {en_i, addr_i};
            for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) en_vec_c[i] = pipe_q[i][AW];
    end

    assign en_o      = pipe_q[DEPTH-1][AW];
    assign addr_o    = pipe_q[DEPTH-1][AW-1:0];
    assign pending_o = |en_vec_c;

endmodule

// File: rtl/tpu_control_unit.sv
// Sequencer for one matrix job on the systolic array: loads K weight rows,
// streams M activation rows, issues bias (C) reads BIAS_LAT cycles behind each
// A read, counts result writebacks and reports done/err.
// Ports: clk, rst (sync, active-high); start + cfg_* job command;
//        core_writeback_valid from the core; ctrl_rd_* buffer reads;
//        ctrl_a_*/ctrl_b_* array controls; ctrl_wr_addr_d result address
//        (combinational from registers); masks, mode; busy/done/err status.
module tpu_control_unit
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = W_DEF,
    parameter int unsigned ADDR_WIDTH           = ADDR_W_DEF,
    parameter int unsigned BIAS_LAT             = BIAS_LAT_DEF,
    parameter int unsigned DRAIN_TIMEOUT        = DRAIN_TIMEOUT_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 cfg_a_base,
    input  logic [ADDR_WIDTH-1:0]                 cfg_b_base,
    input  logic [ADDR_WIDTH-1:0]                 cfg_c_base,
    input  logic [ADDR_WIDTH-1:0]                 cfg_d_base,
    input  logic [ADDR_WIDTH-1:0]                 cfg_m,
    input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cfg_k,
    input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] cfg_n,
    input  logic [2:0]                            cfg_vpu_mode,
    input  logic                                  core_writeback_valid,
    output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_a,
    output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_b,
    output logic [ADDR_WIDTH-1:0]                 ctrl_rd_addr_c,
    output logic                                  ctrl_rd_en_a,
    output logic                                  ctrl_rd_en_b,
    output logic                                  ctrl_rd_en_c,
    output logic                                  ctrl_a_valid,
    output logic                                  ctrl_a_switch,
    output logic                                  ctrl_b_accept_w,
    output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
    output logic [2:0]                            ctrl_vpu_mode,
    output logic [ADDR_WIDTH-1:0]                 ctrl_wr_addr_d,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]       ctrl_row_mask,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]       ctrl_col_mask,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned KW = $clog2(W) + 1;
    localparam int unsigned IW = $clog2(W);
    localparam int unsigned TW = cnt_width(DRAIN_TIMEOUT);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;          // B or A issue index of the current cycle
    logic [AW-1:0]   wb_cnt_q, wb_cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   m_q, m_d;
    logic [AW-1:0]   a_base_q, a_base_d;
    logic [AW-1:0]   d_base_q, d_base_d;
    logic [AW-1:0]   c_src_q, c_src_d;      // C address paired with the A read on the outputs
    logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic            rd_en_a_q, rd_en_a_d, rd_en_b_q, rd_en_b_d;
    logic            a_valid_q, a_valid_d, a_switch_q, a_switch_d;
    logic            accept_w_q, accept_w_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [2:0]      vpu_mode_q, vpu_mode_d;
    logic [W-1:0]    row_mask_q, row_mask_d, col_mask_q, col_mask_d;
    logic [W-1:0]    row_mask_c, col_mask_c;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            cfg_ok_c, abort_c, c_pending_c;

    assign cfg_ok_c = (cfg_m != '0) && (cfg_k != '0) && (cfg_k <= KW'(W))
                   && (cfg_n != '0) && (cfg_n <= KW'(W));

    // Thermometer masks: bit i set when i < K (rows) or i < N (columns).
    always_comb begin
        for (int i = 0; i < int'(W); i++) begin
            row_mask_c[i] = (i < int'(cfg_k));
            col_mask_c[i] = (i < int'(cfg_n));
        end
    end

    // Next-state and registered-output logic. Each issue state holds its read
    // on the outputs for the cycle it is in, so the _d values set up the next read.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_cnt_d   = wb_cnt_q;
        timer_d    = timer_q;
        k_d        = k_q;
        m_d        = m_q;
        a_base_d   = a_base_q;
        d_base_d   = d_base_q;
        c_src_d    = c_src_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        rd_en_a_d  = 1'b0;
        rd_en_b_d  = 1'b0;
        a_valid_d  = 1'b0;
        a_switch_d = 1'b0;
        accept_w_d = 1'b0;
        widx_d     = widx_q;
        vpu_mode_d = vpu_mode_q;
        row_mask_d = row_mask_q;
        col_mask_d = col_mask_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        abort_c    = 1'b0;

        // Writebacks saturate at M so late extras never move the D address.
        if ((state_q == ST_COMPUTE || state_q == ST_DRAIN) && core_writeback_valid
            && (wb_cnt_q != m_q)) begin
            wb_cnt_d = wb_cnt_q + AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d        = cfg_k;
                    m_d        = cfg_m;
                    a_base_d   = cfg_a_base;
                    d_base_d   = cfg_d_base;
                    c_src_d    = cfg_c_base;
                    vpu_mode_d = cfg_vpu_mode;
                    row_mask_d = row_mask_c;
                    col_mask_d = col_mask_c;
                    wb_cnt_d   = '0;
                    if (cfg_ok_c) begin
                        state_d   = ST_LOAD_W;
                        rd_en_b_d = 1'b1;
                        addr_b_d  = cfg_b_base;
                        cnt_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                accept_w_d = 1'b1;
                widx_d     = IW'(cnt_q);
                if (cnt_q == AW'(k_q - KW'(1))) begin
                    state_d   = ST_COMPUTE;
                    rd_en_a_d = 1'b1;
                    addr_a_d  = a_base_q;
                    cnt_d     = '0;
                end else begin
                    rd_en_b_d = 1'b1;
                    addr_b_d  = addr_b_q + AW'(1);
                    cnt_d     = cnt_q + AW'(1);
                end
            end
            ST_COMPUTE: begin
                a_valid_d  = 1'b1;
                a_switch_d = (cnt_q == '0);
                if (cnt_q == m_q - AW'(1)) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end else begin
                    rd_en_a_d = 1'b1;
                    addr_a_d  = addr_a_q + AW'(1);
                    c_src_d   = c_src_q + AW'(1);
                    cnt_d     = cnt_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + TW'(1);
                if ((wb_cnt_q == m_q) && !c_pending_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if ((wb_cnt_q != m_q) && (timer_q == TW'(DRAIN_TIMEOUT - 1))) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    abort_c = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wb_cnt_q   <= '0;
            timer_q    <= '0;
            k_q        <= '0;
            m_q        <= '0;
            a_base_q   <= '0;
            d_base_q   <= '0;
            c_src_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            rd_en_a_q  <= 1'b0;
            rd_en_b_q  <= 1'b0;
            a_valid_q  <= 1'b0;
            a_switch_q <= 1'b0;
            accept_w_q <= 1'b0;
            widx_q     <= '0;
            vpu_mode_q <= '0;
            row_mask_q <= '0;
            col_mask_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            timer_q    <= timer_d;
            k_q        <= k_d;
            m_q        <= m_d;
            a_base_q   <= a_base_d;
            d_base_q   <= d_base_d;
            c_src_q    <= c_src_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            rd_en_a_q  <= rd_en_a_d;
            rd_en_b_q  <= rd_en_b_d;
            a_valid_q  <= a_valid_d;
            a_switch_q <= a_switch_d;
            accept_w_q <= accept_w_d;
            widx_q     <= widx_d;
            vpu_mode_q <= vpu_mode_d;
            row_mask_q <= row_mask_d;
            col_mask_q <= col_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Each A read enters the line the cycle it is on the outputs, so the
    // matching C read leaves exactly BIAS_LAT cycles later.
    ctrl_delay_line #(
        .DEPTH (BIAS_LAT),
        .AW    (AW)
    ) u_c_delay (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (abort_c),
        .en_i      (rd_en_a_q),
        .addr_i    (c_src_q),
        .en_o      (ctrl_rd_en_c),
        .addr_o    (ctrl_rd_addr_c),
        .pending_o (c_pending_c)
    );

    assign ctrl_rd_addr_a      = addr_a_q;
    assign ctrl_rd_addr_b      = addr_b_q;
    assign ctrl_rd_en_a        = rd_en_a_q;
    assign ctrl_rd_en_b        = rd_en_b_q;
    assign ctrl_a_valid        = a_valid_q;
    assign ctrl_a_switch       = a_switch_q;
    assign ctrl_b_accept_w     = accept_w_q;
    assign ctrl_b_weight_index = widx_q;
    assign ctrl_vpu_mode       = vpu_mode_q;
    assign ctrl_wr_addr_d      = d_base_q + wb_cnt_q;
    assign ctrl_row_mask       = row_mask_q;
    assign ctrl_col_mask       = col_mask_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;

endmodule

// File: doc/tpu_control_unit.md
TPU_CONTROL_UNIT -- requirements
Module: tpu_control_unit

Interface
REQ-001 SHALL have parameter SYSTOLIC_ARRAY_WIDTH, default 16, meaning the array dimension W.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the buffer address width.
REQ-003 SHALL have parameter BIAS_LAT, default 40, range 1..255, meaning the cycles from A-row read issue k to C-row read issue k.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1024, meaning the maximum cycles in DRAIN before abort.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle command pulse, sampled only in IDLE.
REQ-008 cfg_a_base, cfg_b_base, cfg_c_base, cfg_d_base  in  ADDR_WIDTH each  base addresses of A, B, C and D.
REQ-009 cfg_m  in  ADDR_WIDTH  number of A rows (M).
REQ-010 cfg_k, cfg_n  in  $clog2(W)+1 each  active rows K and active columns N, legal range 1..W.
REQ-011 cfg_vpu_mode  in  3  VPU mode, latched at start.
REQ-012 core_writeback_valid  in  1  aligned result-row write from the core.
REQ-013 ctrl_rd_addr_a/b/c  out  ADDR_WIDTH each  buffer read addresses.
REQ-014 ctrl_rd_en_a/b/c  out  1 each  buffer read enables.
REQ-015 ctrl_a_valid, ctrl_a_switch, ctrl_b_accept_w  out  1 each  array control signals.
REQ-016 ctrl_b_weight_index  out  $clog2(W)  weight row index.
REQ-017 ctrl_vpu_mode  out  3  latched VPU mode.
REQ-018 ctrl_wr_addr_d  out  ADDR_WIDTH  result write address.
REQ-019 ctrl_row_mask, ctrl_col_mask  out  W each  enable masks.
REQ-020 busy, done, err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-021 SHALL implement the states IDLE, LOAD_W, COMPUTE, DRAIN and DONE.
REQ-022 In IDLE, start SHALL latch all cfg_* inputs and set ctrl_row_mask=(1<<K)-1 and ctrl_col_mask=(1<<N)-1.
REQ-023 In IDLE, start with a legal configuration SHALL go to LOAD_W.
REQ-024 In IDLE, start with cfg_m=0, or cfg_k or cfg_n outside 1..W, SHALL pulse err for one cycle and stay in IDLE.
REQ-025 In LOAD_W, the block SHALL issue ctrl_rd_en_b for K consecutive cycles, with ctrl_rd_addr_b=b_base+i for i=0..K-1.
REQ-026 ctrl_b_accept_w and ctrl_b_weight_index=i SHALL be asserted exactly one cycle after each B read (buffer read latency is 1).
REQ-027 After the last B issue, the block SHALL go to COMPUTE.
REQ-028 In COMPUTE, the block SHALL issue ctrl_rd_en_a for M consecutive cycles, with ctrl_rd_addr_a=a_base+r for r=0..M-1.
REQ-029 ctrl_a_valid SHALL assert one cycle after each A read.
REQ-030 ctrl_a_switch SHALL assert only alongside the valid of row r=0.
REQ-031 ctrl_rd_en_c SHALL assert exactly BIAS_LAT cycles after each ctrl_rd_en_a, with ctrl_rd_addr_c=c_base+r, including when that point falls in DRAIN.
REQ-032 After the last A issue, the block SHALL go to DRAIN.
REQ-033 A writeback counter SHALL count core_writeback_valid in COMPUTE and DRAIN.
REQ-034 ctrl_wr_addr_d SHALL equal d_base plus the writeback count, combinationally valid in the cycle of each writeback.
REQ-035 In DRAIN, the block SHALL go to DONE when the writeback count reaches M and no C issue is pending.
REQ-036 In DRAIN, if the writeback count has not reached M within DRAIN_TIMEOUT cycles, the block SHALL pulse err, clear pending C issues and go to IDLE.
REQ-037 DONE SHALL pulse done for one cycle and then go to IDLE.
REQ-038 busy SHALL be 1 in every state except IDLE.
REQ-039 start while busy SHALL be ignored.
REQ-040 core_writeback_valid in IDLE SHALL be ignored.
REQ-041 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-042 Writebacks beyond M SHALL not advance ctrl_wr_addr_d.

Reset
REQ-043 While rst is high, the state SHALL go to IDLE and every output SHALL be 0, including masks, addresses, mode and the C delay line.
REQ-044 Reset mid-operation SHALL abort the job within one cycle, and no done or err pulse SHALL follow.

Structure
REQ-045 A shared package tpu_ctrl_pkg SHALL hold the state enum and the W, BIAS_LAT and counter-width constants.
REQ-046 One sub-module, ctrl_delay_line (parameter DEPTH, payload {en, addr}, synchronous clear), SHALL implement the A-to-C delay.

Verification
REQ-047 Bench SHALL cover: W=16, K=16, N=16, M=4 -> 16 B reads with weight_index 0..15; A reads at a_base..a_base+3; switch with row 0 only; C reads BIAS_LAT cycles after each A; 4 writebacks at d_base..d_base+3; done is one pulse.
REQ-048 Bench SHALL cover: K=3, N=5 -> row_mask=0x0007, col_mask=0x001F; exactly 3 accept_w cycles.
REQ-049 Bench SHALL cover: cfg_n=0 or cfg_k=17 -> err pulse; busy stays 0; no read enables.
REQ-050 Bench SHALL cover: a_base=1022, M=4, ADDR_WIDTH=10 -> A addresses 1022, 1023, 0, 1.
REQ-051 Bench SHALL cover: only 3 of 4 writebacks arrive -> err after DRAIN_TIMEOUT cycles; return to IDLE; no done.
REQ-052 Bench SHALL cover: rst during COMPUTE, and start while busy -> all outputs 0 the next cycle; ignored start produces no second job.
